audio_sample_capture: RTL and testbench
=======================================

Name: audio_sample_capture

Overview:
- Sits directly downstream of the serial audio converter, in the system clock domain.
- Synchronises AUD_LRCK and captures each completed left/right pair from the converter's parallel AUD_inL/AUD_inR registers.
- Buffers captured pairs in a small first-word-fall-through FIFO and hands them to the memory writer over a valid/ready handshake.
- Tracks FIFO occupancy and overflow.

Parameters:
- DATA_W, 16: sample width per channel.
- FIFO_DEPTH, 8: stereo-pair entries; power of two, at least 2.
- SYNC_STAGES, 2: flops in the AUD_LRCK synchroniser; at least 2.

Ports:
- iCLK  in  1  system clock; must run at least 8x AUD_BCK.
- iRST  in  1  asynchronous, active-high reset.
- iENABLE  in  1  capture enable; when low, no new pairs are pushed.
- AUD_LRCK  in  1  left-right clock, asynchronous to iCLK.
- AUD_inL  in  DATA_W  left sample from converter; complete and stable while AUD_LRCK is low.
- AUD_inR  in  DATA_W  right sample from converter; complete and stable while AUD_LRCK is high.
- oSAMPLE_L  out  DATA_W  left sample at FIFO head.
- oSAMPLE_R  out  DATA_W  right sample at FIFO head.
- oVALID  out  1  FIFO not empty.
- iREADY  in  1  consumer accepts head pair.
- oLEVEL  out  clog2(FIFO_DEPTH)+1  entries currently stored.
- oOVERFLOW  out  1  sticky: a pair was dropped because the FIFO was full.
- iCLR_OVF  in  1  synchronous clear of oOVERFLOW.

Behaviour:
- Reset (iRST high, async):
  - Synchroniser flops and the edge-detect prev register cleared to 0.
  - have_L = 0, hold_L = 0, FIFO pointers = 0.
  - oVALID = 0, oLEVEL = 0, oOVERFLOW = 0, oSAMPLE_L/R = 0.
- Synchroniser: AUD_LRCK passes through SYNC_STAGES flops, then a prev register.
  - fall = ~sync & prev; rise = sync & ~prev.
- Falling edge (left word now complete in AUD_inL):
  - If iENABLE: hold_L <= AUD_inL and have_L <= 1.
- Rising edge (right word complete):
  - If iENABLE and have_L: push {hold_L, AUD_inR} into the FIFO and clear have_L.
  - If have_L = 0: no push. This guarantees the first pushed pair after reset or enable is whole.
  - A rise seen right after reset release (AUD_LRCK already high) is therefore harmless.
- iENABLE low: have_L cleared every cycle; the FIFO continues to drain normally.
- Latency: if AUD_LRCK rises before iCLK edge k (captured by the first sync flop at k), the push is written at edge k+SYNC_STAGES. oVALID is high after that edge if the FIFO was empty.
- FIFO (first-word-fall-through):
  - oSAMPLE_L/R show the head entry combinationally from storage.
  - Pop occurs on a cycle with oVALID && iREADY.
  - oVALID = (oLEVEL != 0).
  - oSAMPLE_L/R hold their last values when empty; no X.
- Push when full:
  - Without a simultaneous pop: the pair is dropped, the FIFO is unchanged, and oOVERFLOW <= 1.
  - With a simultaneous pop: the push is accepted and oLEVEL is unchanged.
- Simultaneous push and pop when empty: push accepted, pop ignored (oVALID was 0); oLEVEL becomes 1.
- Pointers wrap modulo FIFO_DEPTH. oLEVEL ranges 0..FIFO_DEPTH and saturates at neither end beyond those bounds.
- oOVERFLOW: cleared by iCLR_OVF. If a clear and a drop occur in the same cycle, set wins.
- iREADY while oVALID = 0 has no effect.

Optional Feature:
- Macro AUDIO_CAPTURE_MONO_EN adds output oMONO, DATA_W bits.
- oMONO = signed (oSAMPLE_L + oSAMPLE_R) computed at DATA_W+1 bits, then arithmetic-shifted right by 1. Combinational from the FIFO head.
- Example: L = 16'h7FFF, R = 16'h7FFF gives 16'h7FFF; L = 16'h8000, R = 16'h8000 gives 16'h8000.
- Without the macro, the port and logic are absent and behaviour is otherwise identical.

Test Plan:
1. Reset with AUD_LRCK high, release, then 3 LRCK frames with L = 16'h1234/R = 16'hABCD, iREADY = 1:
   - no push from the initial high level;
   - 3 pops of L = 16'h1234, R = 16'hABCD;
   - each oVALID assertion occurs SYNC_STAGES edges after the rising LRCK edge is sampled.
2. iREADY = 0, 10 frames with incrementing L = 16'h0001.., R = L+16'h0100, FIFO_DEPTH = 8:
   - oLEVEL reaches 8, oOVERFLOW = 1;
   - draining yields L = 1..8 in order; frames 9 and 10 are lost.
3. FIFO full, next push aligned to a cycle with oVALID && iREADY:
   - oLEVEL stays 8, no overflow;
   - the new pair appears last on drain.
4. Drop iENABLE mid-frame (after the falling edge, before the rising edge), re-enable on the next low phase:
   - the partial pair is not pushed;
   - the next full frame is pushed intact.
5. Assert iCLR_OVF in the same cycle as a full-FIFO drop: oOVERFLOW stays 1. Assert iCLR_OVF alone on the next cycle: oOVERFLOW = 0.
6. Assert iRST mid-drain with oLEVEL = 5: asynchronously oVALID = 0, oLEVEL = 0, oSAMPLE_L/R = 0. After release, the first push again requires a falling then a rising LRCK edge.

Source files
------------

// File: rtl/audio_sample_capture.sv
// Purpose : captures complete left/right pairs from the serial audio converter into a FWFT FIFO.
// Latency : a rising AUD_LRCK first sampled at edge k is written at edge k+SYNC_STAGES; the head shows with no added delay.
// Backpressure: valid/ready at the output; a pair that arrives while the FIFO is full with no pop is dropped and flagged in oOVERFLOW.
//
// Ports:
//   iCLK, iRST            system clock, asynchronous active-high reset
//   iENABLE               capture enable (the FIFO keeps draining while low)
//   AUD_LRCK              left/right clock, asynchronous to iCLK
//   AUD_inL, AUD_inR      parallel words from the converter
//   oSAMPLE_L/R, oVALID   FIFO head pair and its valid flag
//   iREADY                consumer accepts the head pair
//   oLEVEL                number of stored pairs (0..FIFO_DEPTH)
//   oOVERFLOW, iCLR_OVF   sticky drop flag and its synchronous clear
//   oMONO                 (only with AUDIO_CAPTURE_MONO_EN) (L+R)/2 of the head pair
module audio_sample_capture #(
  parameter int DATA_W      = 16,
  parameter int FIFO_DEPTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                          iCLK,
  input  logic                          iRST,
  input  logic                          iENABLE,
  input  logic                          AUD_LRCK,
  input  logic [DATA_W-1:0]             AUD_inL,
  input  logic [DATA_W-1:0]             AUD_inR,
  output logic [DATA_W-1:0]             oSAMPLE_L,
  output logic [DATA_W-1:0]             oSAMPLE_R,
  output logic                          oVALID,
  input  logic                          iREADY,
  output logic [$clog2(FIFO_DEPTH):0]   oLEVEL,
  output logic                          oOVERFLOW,
  input  logic                          iCLR_OVF
`ifdef AUDIO_CAPTURE_MONO_EN
  ,
  output logic [DATA_W-1:0]             oMONO
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(FIFO_DEPTH);

  // LRCK synchroniser and edge detect
  logic [SYNC_STAGES-1:0] lrck_sync;
  logic                   lrck_prev;
  logic                   lrck_s;
  logic                   lrck_fall;
  logic                   lrck_rise;

  assign lrck_s    = lrck_sync[SYNC_STAGES-1];
  assign lrck_fall = ~lrck_s & lrck_prev;
  assign lrck_rise = lrck_s & ~lrck_prev;

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      lrck_sync <= '0;
      lrck_prev <= 1'b0;
    end else begin
      lrck_sync <= {lrck_sync[SYNC_STAGES-2:0], AUD_LRCK};
      lrck_prev <= lrck_s;
    end
  end

  // Left word holding register. have_l only comes up on a falling edge seen
  // while enabled, so the first pair pushed after reset or re-enable is whole.
  logic              have_l;
  logic [DATA_W-1:0] hold_l;

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      have_l <= 1'b0;
      hold_l <= '0;
    end else if (!iENABLE) begin
      have_l <= 1'b0;
    end else if (lrck_fall) begin
      have_l <= 1'b1;
      hold_l <= AUD_inL;
    end else if (lrck_rise) begin
      have_l <= 1'b0;
    end
  end

  // FIFO control
  logic                  push_req;
  logic                  pop;
  logic                  full;
  logic                  push_ok;
  logic                  drop;
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [2*DATA_W-1:0]   mem [FIFO_DEPTH];
  logic [DATA_W-1:0]     last_l;
  logic [DATA_W-1:0]     last_r;

  assign push_req = lrck_rise & iENABLE & have_l;
  assign oVALID   = (oLEVEL != '0);
  assign pop      = oVALID & iREADY;
  assign full     = (oLEVEL == FULL_LVL);
  // A full FIFO still accepts a push when a pop frees the head slot in the same cycle.
  assign push_ok  = push_req & (~full | pop);
  assign drop     = push_req & full & ~pop;

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      oLEVEL    <= '0;
      oOVERFLOW <= 1'b0;
      last_l    <= '0;
      last_r    <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= {hold_l, AUD_inR};
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push_ok && !pop)      oLEVEL <= oLEVEL + 1'b1;
      else if (pop && !push_ok) oLEVEL <= oLEVEL - 1'b1;
      // A drop in the same cycle as a clear leaves the flag set.
      if (drop)          oOVERFLOW <= 1'b1;
      else if (iCLR_OVF) oOVERFLOW <= 1'b0;
      // Remember the pair on display so the outputs hold it once the FIFO empties.
      if (oVALID) begin
        last_l <= mem[rd_ptr][2*DATA_W-1:DATA_W];
        last_r <= mem[rd_ptr][DATA_W-1:0];
      end
    end
  end

  assign oSAMPLE_L = oVALID ? mem[rd_ptr][2*DATA_W-1:DATA_W] : last_l;
  assign oSAMPLE_R = oVALID ? mem[rd_ptr][DATA_W-1:0]        : last_r;

`ifdef AUDIO_CAPTURE_MONO_EN
  // One extra bit holds the full sum; dropping its LSB is the arithmetic shift.
  logic signed [DATA_W:0] mono_sum;
  assign mono_sum = $signed({oSAMPLE_L[DATA_W-1], oSAMPLE_L})
                  + $signed({oSAMPLE_R[DATA_W-1], oSAMPLE_R});
  assign oMONO    = mono_sum[DATA_W:1];
`endif

endmodule

// File: tb/tb_audio_sample_capture.sv
// Purpose : directed self-checking bench for audio_sample_capture.
// Latency : inputs driven 1 ns after a rising edge, outputs sampled at the same point.
// Backpressure: iREADY pulsed by the bench to pop one pair at a time.
module tb_audio_sample_capture;

  logic        clk;
  logic        rst;
  logic        en;
  logic        lrck;
  logic [15:0] in_l;
  logic [15:0] in_r;
  logic [15:0] smp_l;
  logic [15:0] smp_r;
  logic        vld;
  logic        rdy;
  logic [3:0]  level;
  logic        ovf;
  logic        clr_ovf;
`ifdef AUDIO_CAPTURE_MONO_EN
  logic [15:0] mono;
`endif

  int errors = 0;
  int checks = 0;

  audio_sample_capture #(.DATA_W(16), .FIFO_DEPTH(8), .SYNC_STAGES(2)) dut (
    .iCLK      (clk),
    .iRST      (rst),
    .iENABLE   (en),
    .AUD_LRCK  (lrck),
    .AUD_inL   (in_l),
    .AUD_inR   (in_r),
    .oSAMPLE_L (smp_l),
    .oSAMPLE_R (smp_r),
    .oVALID    (vld),
    .iREADY    (rdy),
    .oLEVEL    (level),
    .oOVERFLOW (ovf),
    .iCLR_OVF  (clr_ovf)
`ifdef AUDIO_CAPTURE_MONO_EN
    ,
    .oMONO     (mono)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One LRCK period: six cycles low (left word), six cycles high (right word).
  task automatic frame(input logic [15:0] l, input logic [15:0] r);
    lrck = 1'b0;
    in_l = l;
    repeat (6) tick();
    lrck = 1'b1;
    in_r = r;
    repeat (6) tick();
  endtask

  task automatic pop_one();
    rdy = 1'b1;
    tick();
    rdy = 1'b0;
  endtask

  initial begin
    rst = 1'b1; lrck = 1'b1; en = 1'b1; rdy = 1'b1; clr_ovf = 1'b0;
    in_l = 16'h0; in_r = 16'h0;
    tick(); tick();
    check("rst_valid", vld, 0);
    check("rst_level", level, 0);
    check("rst_ovf", ovf, 0);
    check("rst_sample_l", smp_l, 0);
    check("rst_sample_r", smp_r, 0);

    // 1: release with LRCK high, then three frames with exact push latency
    rst = 1'b0;
    repeat (8) tick();
    check("t1_no_push_init_high", vld, 0);
    for (int f = 0; f < 3; f++) begin
      lrck = 1'b0;
      in_l = 16'h1234;
      repeat (6) tick();
      lrck = 1'b1;
      in_r = 16'hABCD;
      tick();
      check("t1_lat_edge_k", vld, 0);
      tick();
      check("t1_lat_edge_k1", vld, 0);
      tick();
      check("t1_lat_edge_k2_valid", vld, 1);
      check("t1_sample_l", smp_l, 16'h1234);
      check("t1_sample_r", smp_r, 16'hABCD);
      tick();
      check("t1_popped", vld, 0);
      repeat (2) tick();
    end

    // 2: fill past full with no consumer, drain in order
    rdy = 1'b0;
    for (int i = 1; i <= 10; i++) frame(16'(i), 16'(i + 16'h0100));
    check("t2_level_full", level, 8);
    check("t2_ovf_set", ovf, 1);
    for (int i = 1; i <= 8; i++) begin
      check("t2_drain_l", smp_l, i);
      check("t2_drain_r", smp_r, i + 16'h0100);
      pop_one();
    end
    check("t2_empty_valid", vld, 0);
    check("t2_empty_level", level, 0);
    check("t2_hold_l", smp_l, 16'h0008);
    check("t2_hold_r", smp_r, 16'h0108);
    check("t2_ovf_sticky", ovf, 1);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    check("t2_ovf_cleared", ovf, 0);

    // 3: push onto a full FIFO in the same cycle as a pop
    for (int i = 1; i <= 8; i++) frame(16'(16'h0020 + i), 16'(16'h0040 + i));
    check("t3_level_full", level, 8);
    lrck = 1'b0;
    in_l = 16'h0030;
    repeat (6) tick();
    lrck = 1'b1;
    in_r = 16'h0031;
    tick(); tick();
    rdy = 1'b1;
    tick();
    rdy = 1'b0;
    check("t3_level_stays", level, 8);
    check("t3_no_ovf", ovf, 0);
    repeat (3) tick();
    for (int i = 0; i < 8; i++) begin
      check("t3_drain_l", smp_l, (i < 7) ? 32'h22 + i : 32'h30);
      pop_one();
    end
    check("t3_last_r", smp_r, 16'h0031);
    check("t3_empty", level, 0);

    // 4: disable between the falling and rising edges
    lrck = 1'b0;
    in_l = 16'h0055;
    repeat (4) tick();
    en = 1'b0;
    repeat (2) tick();
    lrck = 1'b1;
    in_r = 16'h0066;
    repeat (6) tick();
    check("t4_partial_dropped", level, 0);
    en = 1'b1;
    frame(16'h0077, 16'h0088);
    check("t4_level", level, 1);
    check("t4_sample_l", smp_l, 16'h0077);
    check("t4_sample_r", smp_r, 16'h0088);
    pop_one();
    check("t4_empty", level, 0);

    // 5: clear coinciding with a drop, then clear alone
    for (int i = 1; i <= 8; i++) frame(16'(16'h0060 + i), 16'(16'h0080 + i));
    check("t5_ovf_before", ovf, 0);
    lrck = 1'b0;
    in_l = 16'h0070;
    repeat (6) tick();
    lrck = 1'b1;
    in_r = 16'h0071;
    tick(); tick();
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    check("t5_set_wins", ovf, 1);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    check("t5_clear_alone", ovf, 0);
    check("t5_level", level, 8);
    repeat (2) tick();

    // 6: asynchronous reset mid-drain
    rdy = 1'b1;
    repeat (3) tick();
    rdy = 1'b0;
    check("t6_level5", level, 5);
    check("t6_head", smp_l, 16'h0064);
    rst = 1'b1;
    #1;
    check("t6_async_valid", vld, 0);
    check("t6_async_level", level, 0);
    check("t6_async_l", smp_l, 0);
    check("t6_async_r", smp_r, 0);
    tick(); tick();
    rst = 1'b0;
    repeat (8) tick();
    check("t6_no_push_after_rst", level, 0);
    frame(16'h0099, 16'h00AA);
    check("t6_level", level, 1);
    check("t6_sample_l", smp_l, 16'h0099);
    check("t6_sample_r", smp_r, 16'h00AA);
`ifdef AUDIO_CAPTURE_MONO_EN
    check("mono_avg", mono, 16'h00A1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
